// File: rtl/project1_nios2_qsys_0_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : project1_nios2_qsys_0_oci_dct_pkg
// Brief    : Shared widths and FSM encoding for the OCI DCT frame packer.
// Revision : 1.0 - initial release
// ============================================================================
package project1_nios2_qsys_0_oci_dct_pkg;

  localparam int SYM_W      = 3;
  localparam int FRAME_SYMS = 10;
  localparam int BUF_W      = SYM_W * FRAME_SYMS;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } dct_state_t;

endpackage
`default_nettype wire

// File: rtl/project1_nios2_qsys_0_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// Module   : project1_nios2_qsys_0_oci_dct_outreg
// Brief    : Single-entry valid/ready holding register for packed DCT frames.
// Revision : 1.0 - initial release
// ============================================================================
module project1_nios2_qsys_0_oci_dct_outreg
  import project1_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count
);

  logic             r_valid;
  logic [BUF_W-1:0] r_buffer;
  logic [CNT_W-1:0] r_count;

  // Caller only asserts load when the slot is empty or being drained this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_buffer <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_valid  <= 1'b1;
      r_buffer <= load_buffer;
      r_count  <= load_count;
    end else if (frame_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign frame_valid = r_valid;
  assign dct_buffer  = r_buffer;
  assign dct_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/project1_nios2_qsys_0_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : project1_nios2_qsys_0_oci_dct_packer
// Brief    : Packs 3-bit trace symbols into 30-bit DCT frames; flushes on test end.
// Revision : 1.0 - initial release
// ============================================================================
module project1_nios2_qsys_0_oci_dct_packer
  import project1_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  input  logic             test_ending,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             test_has_ended
);

  localparam logic [CNT_W-1:0] c_full = CNT_W'(FRAME_SYMS);

  dct_state_t       r_state;
  logic [BUF_W-1:0] r_acc;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_ended;

  logic             w_out_free;
  logic             w_accept;
  logic [BUF_W-1:0] w_acc_in;
  logic [CNT_W-1:0] w_cnt_in;
  logic             w_load;

  assign w_out_free = !frame_valid || frame_ready;
  assign sym_ready  = !reset && (r_state == ST_RUN) && (r_acc_cnt != c_full);
  assign w_accept   = sym_valid && sym_ready;
  assign w_cnt_in   = r_acc_cnt + CNT_W'(w_accept);

  always_comb begin
    w_acc_in = r_acc;
    for (int k = 0; k < FRAME_SYMS; k++) begin
      if (w_accept && (r_acc_cnt == CNT_W'(k)))
        w_acc_in[k*SYM_W +: SYM_W] = sym_data;
    end
  end

  // A full accumulator transfers in RUN; any non-empty one transfers in FLUSH.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_RUN:   w_load = (w_cnt_in == c_full) && w_out_free;
      ST_FLUSH: w_load = (r_acc_cnt != '0) && w_out_free;
      default:  w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_ended   <= 1'b0;
    end else begin
      if (w_load) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc     <= w_acc_in;
        r_acc_cnt <= w_cnt_in;
      end
      case (r_state)
        ST_RUN:   if (test_ending) r_state <= ST_FLUSH;
        ST_FLUSH: if ((r_acc_cnt == '0) || w_load) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!frame_valid) begin
            r_state <= ST_ENDED;
            r_ended <= 1'b1;
          end
        end
        default:  r_state <= ST_ENDED;
      endcase
    end
  end

  assign test_has_ended = r_ended;

  project1_nios2_qsys_0_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (w_load),
    .load_buffer (w_acc_in),
    .load_count  (w_cnt_in),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_project1_nios2_qsys_0_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_project1_nios2_qsys_0_oci_dct_packer
// Brief    : Directed self-checking bench for the OCI DCT frame packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_project1_nios2_qsys_0_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        sym_valid;
  logic [2:0]  sym_data;
  logic        sym_ready;
  logic        test_ending;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int checks   = 0;
  int failures = 0;

  logic [29:0] q_buf[$];
  logic [3:0]  q_cnt[$];

  project1_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .sym_valid      (sym_valid),
    .sym_data       (sym_data),
    .sym_ready      (sym_ready),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sink model: records every frame handshake, sampled just before the rising edge.
  always @(negedge clk) begin
    #4;
    if (!reset && frame_valid && frame_ready) begin
      q_buf.push_back(dct_buffer);
      q_cnt.push_back(dct_count);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] s);
    sym_valid = 1'b1;
    sym_data  = s;
    #1;
    chk("sym_ready_on_push", 32'(sym_ready), 32'd1);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    sym_valid   = 1'b0;
    test_ending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ended(input int max_cyc);
    int n = 0;
    while (!test_has_ended && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("test_has_ended_reached", 32'(test_has_ended), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    sym_valid   = 1'b0;
    sym_data    = 3'd0;
    test_ending = 1'b0;
    frame_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_test_has_ended", 32'(test_has_ended), 32'd0);
    chk("rst_sym_ready", 32'(sym_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_sym_ready", 32'(sym_ready), 32'd1);

    // One full frame, symbols 0..7,0,1
    @(negedge clk);
    frame_ready = 1'b1;
    for (int i = 0; i < 9; i++) push(3'(i));
    chk("t1_fv_before_10th", 32'(frame_valid), 32'd0);
    push(3'd1);
    chk("t1_fv_after_10th", 32'(frame_valid), 32'd1);
    chk("t1_count", 32'(dct_count), 32'd10);
    chk("t1_buffer", 32'(dct_buffer), 32'(30'o1076543210));
    @(negedge clk);
    chk("t1_fv_drained", 32'(frame_valid), 32'd0);
    chk("t1_frames", 32'(q_buf.size()), 32'd1);

    // 25 continuous symbols then flush of the 5-symbol tail
    q_buf.delete();
    q_cnt.delete();
    for (int i = 0; i < 25; i++) push(3'(i));
    test_ending = 1'b1;
    @(negedge clk);
    test_ending = 1'b0;
    wait_ended(20);
    chk("t2_frames", 32'(q_buf.size()), 32'd3);
    if (q_buf.size() == 3) begin
      chk("t2_buf0", 32'(q_buf[0]), 32'(30'o1076543210));
      chk("t2_cnt0", 32'(q_cnt[0]), 32'd10);
      chk("t2_buf1", 32'(q_buf[1]), 32'(30'o3210765432));
      chk("t2_cnt1", 32'(q_cnt[1]), 32'd10);
      chk("t2_buf2", 32'(q_buf[2]), 32'(30'o0000007654));
      chk("t2_cnt2", 32'(q_cnt[2]), 32'd5);
    end
    chk("t2_ended_sym_ready", 32'(sym_ready), 32'd0);
    chk("t2_ended_fv", 32'(frame_valid), 32'd0);

    // Sink backpressure: second frame accumulates, then input stalls
    do_reset();
    frame_ready = 1'b0;
    q_buf.delete();
    q_cnt.delete();
    for (int i = 0; i < 10; i++) push(3'(7 - i));
    chk("t3_fv_a", 32'(frame_valid), 32'd1);
    chk("t3_buf_a", 32'(dct_buffer), 32'(30'o6701234567));
    for (int i = 0; i < 10; i++) push(3'd3);
    sym_valid = 1'b1;
    sym_data  = 3'd2;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_stall_sym_ready", 32'(sym_ready), 32'd0);
      chk("t3_hold_buf", 32'(dct_buffer), 32'(30'o6701234567));
      chk("t3_hold_fv", 32'(frame_valid), 32'd1);
      @(negedge clk);
    end
    sym_valid   = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    chk("t3_fv_b", 32'(frame_valid), 32'd1);
    chk("t3_buf_b", 32'(dct_buffer), 32'(30'o3333333333));
    chk("t3_cnt_b", 32'(dct_count), 32'd10);
    @(negedge clk);
    chk("t3_fv_drained", 32'(frame_valid), 32'd0);
    chk("t3_frames", 32'(q_buf.size()), 32'd2);
    if (q_buf.size() == 2) begin
      chk("t3_q0", 32'(q_buf[0]), 32'(30'o6701234567));
      chk("t3_q1", 32'(q_buf[1]), 32'(30'o3333333333));
    end

    // Empty flush: no frame, ended two edges after entering FLUSH
    q_buf.delete();
    q_cnt.delete();
    test_ending = 1'b1;
    @(negedge clk);
    test_ending = 1'b0;
    chk("t4_not_ended_yet", 32'(test_has_ended), 32'd0);
    chk("t4_flush_sym_ready", 32'(sym_ready), 32'd0);
    @(negedge clk);
    chk("t4_fv_drain", 32'(frame_valid), 32'd0);
    @(negedge clk);
    chk("t4_ended", 32'(test_has_ended), 32'd1);
    chk("t4_fv_ended", 32'(frame_valid), 32'd0);
    chk("t4_no_frames", 32'(q_buf.size()), 32'd0);

    // test_ending coincident with the 4th symbol accept
    do_reset();
    frame_ready = 1'b1;
    q_buf.delete();
    q_cnt.delete();
    push(3'd1);
    push(3'd2);
    push(3'd3);
    test_ending = 1'b1;
    push(3'd4);
    test_ending = 1'b0;
    wait_ended(20);
    chk("t5_frames", 32'(q_buf.size()), 32'd1);
    if (q_buf.size() == 1) begin
      chk("t5_cnt", 32'(q_cnt[0]), 32'd4);
      chk("t5_buf", 32'(q_buf[0]), 32'(30'o4321));
    end

    // Asynchronous reset with a held frame and a partial accumulator
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(3'd1);
    for (int i = 0; i < 6; i++) push(3'd2);
    chk("t6_fv_pre_reset", 32'(frame_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_fv", 32'(frame_valid), 32'd0);
    chk("t6_async_buf", 32'(dct_buffer), 32'd0);
    chk("t6_async_cnt", 32'(dct_count), 32'd0);
    chk("t6_async_sym_ready", 32'(sym_ready), 32'd0);
    chk("t6_async_ended", 32'(test_has_ended), 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    frame_ready = 1'b1;
    #1;
    chk("t6_release_sym_ready", 32'(sym_ready), 32'd1);
    chk("t6_release_fv", 32'(frame_valid), 32'd0);
    for (int i = 0; i < 10; i++) push(3'd5);
    chk("t6_fresh_fv", 32'(frame_valid), 32'd1);
    chk("t6_fresh_buf", 32'(dct_buffer), 32'(30'o5555555555));
    chk("t6_fresh_cnt", 32'(dct_count), 32'd10);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
